shift_inverse_ctrl: RTL
=======================

// Module: shift_inverse_ctrl
// PURPOSE
//  Sequencer for the shift_inverse datapath (4 x 32-bit word shift/inverse block).
//  - Accepts 32-bit words over a valid/ready stream and drives datapath set/register.
//  - Waits out datapath latency, then snapshots dp_shift[3:0] into a 128-bit result.
//  - Presents the result on a valid/ready output stream; one block (4 words) at a time.
// PARAMETERS
//  NWORDS   4   words per block (= datapath depth); must be >= 2
//  DP_LAT   1   cycles from datapath sampling the last word to dp_shift valid; >= 1
//  CNT_W    16  width of completed-block counter
// PORTS
//  clk          in   1          system clock, rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  flush        in   1          sync abort: drop partial block / pending result
//  in_valid     in   1          input word valid
//  in_ready     out  1          controller can take a word
//  in_data      in   32         input word
//  dp_set       out  1          datapath load strobe (one cycle per accepted word)
//  dp_register  out  32         word presented to datapath
//  dp_shift     in   [3:0][31:0] datapath state
//  out_valid    out  1          result valid
//  out_ready    in   1          downstream accepts result
//  out_data     out  [3:0][31:0] captured block result
//  busy         out  1          block in progress (state != LOAD or wcnt != 0)
//  blk_cnt      out  CNT_W      completed (handshaken) blocks, wraps
// BEHAVIOUR
//  Reset (async, reset_n=0): state=LOAD, wcnt=0, in_ready=0 while reset asserted,
//   dp_set=0, dp_register=0, out_valid=0, out_data=0, busy=0, blk_cnt=0.
//   Partial block discarded; reset mid-block or mid-output has no residue.
//  States: LOAD -> WAIT -> OUT -> LOAD.
//  LOAD: in_ready=1 (combinational from state). Accept = in_valid & in_ready.
//   On accept at edge E: dp_register<=in_data, dp_set<=1 (high exactly cycle E..E+1),
//   wcnt++. No accept: dp_set<=0, dp_register holds. Gaps allowed anywhere.
//   Accept with wcnt==NWORDS-1: wcnt<=0, lcnt<=0, state<=WAIT.
//  WAIT: in_ready=0; lcnt counts DP_LAT+1 cycles (1 for dp_set sample + DP_LAT).
//   At edge ending WAIT: out_data<=dp_shift, out_valid<=1, state<=OUT.
//   DP_LAT=1: last word accepted at edge E -> out_valid high after edge E+2.
//  OUT: in_ready=0; out_data/out_valid held stable until out_ready.
//   out_valid & out_ready at edge: out_valid<=0, blk_cnt++ (all-ones -> 0), state<=LOAD.
//   Next word can be accepted the cycle after the output handshake (no overlap).
//  flush (sync, highest priority over all handshakes): state<=LOAD, wcnt<=0,
//   dp_set<=0, out_valid<=0; blk_cnt and out_data unchanged. in_valid ignored that cycle.
//  out_valid never drops without out_ready or flush/reset. No combinational in->out path.
// STRUCTURE
//  Package shift_inverse_pkg: NWORDS default, word_t (logic [31:0]),
//   blk_t (word_t [3:0]), ctrl_state_e {LOAD, WAIT, OUT}.
//  Single module, no sub-module; shift_inverse instanced alongside at parent level.
//  wcnt width $clog2(NWORDS); lcnt width $clog2(DP_LAT+2).
// TESTING
//  Bench: clk period 10, ctrl + real shift_inverse; reference captures dp_shift at WAIT exit.
//  1 Words 0C011001,C1010001,CA010001,0A0B0B01 back-to-back, out_ready=1 -> 4 dp_set pulses,
//    out_valid after edge E+2, out_data == dp_shift snapshot, blk_cnt=1.
//  2 Same words, in_valid gap of 3 cycles after word 2 -> dp_set low in gap, same out_data.
//  3 out_ready=0 for 5 cycles in OUT -> out_valid/out_data stable, in_ready=0, blk_cnt 0->1
//    only on handshake edge.
//  4 flush after 2 words, then 4 new words -> one result from new words only, blk_cnt=1.
//  5 reset_n low during WAIT -> outputs at reset values immediately; next 4 words -> 1 block.
//  6 CNT_W=2, 5 blocks -> blk_cnt 1,2,3,0,1; no dropped or duplicated result.

Source files
------------

// File: rtl/shift_inverse_pkg.sv
// Shared types for the shift_inverse controller and its datapath.
//   NWORDS_DEF   : default number of 32-bit words per block
//   word_t       : one 32-bit data word
//   blk_t        : one block of four words (the datapath state)
//   ctrl_state_e : controller sequencing states
package shift_inverse_pkg;

  localparam int NWORDS_DEF = 4;

  typedef logic [31:0] word_t;
  typedef word_t [3:0] blk_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/shift_inverse_ctrl_if.sv
// Word-input and block-output streams of the shift_inverse controller.
//   in_valid/in_ready/in_data    : 32-bit word stream into the controller
//   out_valid/out_ready/out_data : 128-bit block result stream out of it
// The slave modport is the controller's view; master is the producer/consumer side.
interface shift_inverse_ctrl_if;
  import shift_inverse_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  out_valid;
  logic  out_ready;
  blk_t  out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_inverse_ctrl.sv
// Sequencer for the shift_inverse datapath.
// Takes NWORDS words from the input stream, strobes each into the datapath,
// waits out the datapath latency, snapshots dp_shift and offers it as one
// block on the output stream. One block is in flight at a time.
// Ports:
//   clk, reset_n  : clock (rising edge), asynchronous active-low reset
//   flush         : synchronous abort of the partial block / pending result
//   s             : word input and block output streams (slave modport)
//   dp_set        : datapath load strobe, one cycle per accepted word
//   dp_register   : word presented to the datapath
//   dp_shift      : datapath state
//   busy          : a block is in progress
//   blk_cnt       : count of handshaken result blocks, wraps
module shift_inverse_ctrl
  import shift_inverse_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int DP_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  shift_inverse_ctrl_if.slave   s,
  output logic                  dp_set,
  output word_t                 dp_register,
  input  blk_t                  dp_shift,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int WCNT_W = $clog2(NWORDS);
  localparam int LCNT_W = $clog2(DP_LAT + 2);

  ctrl_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              dp_set_q, dp_set_d;
  word_t             dp_register_q, dp_register_d;
  logic              out_valid_q, out_valid_d;
  blk_t              out_data_q, out_data_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  // Low while reset is held and for the first edge after release, so that
  // in_ready is never asserted during reset.
  logic              rdy_q, rdy_d;
  logic              in_ready;
  logic              accept;

  assign in_ready = rdy_q && (state_q == LOAD);
  assign accept   = s.in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    lcnt_d        = lcnt_q;
    dp_set_d      = 1'b0;
    dp_register_d = dp_register_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    blk_cnt_d     = blk_cnt_q;
    rdy_d         = 1'b1;

    // flush outranks every handshake, including a pending output handshake.
    if (flush) begin
      state_d     = LOAD;
      wcnt_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            dp_register_d = s.in_data;
            dp_set_d      = 1'b1;
            if (wcnt_q == WCNT_W'(NWORDS - 1)) begin
              wcnt_d  = '0;
              lcnt_d  = '0;
              state_d = WAIT;
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
            end
          end
        end
        // One cycle for the datapath to sample the last dp_set, then DP_LAT.
        WAIT: begin
          if (lcnt_q == LCNT_W'(DP_LAT)) begin
            out_data_d  = dp_shift;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
        OUT: begin
          if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
            blk_cnt_d   = blk_cnt_q + CNT_W'(1);
            state_d     = LOAD;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LOAD;
      wcnt_q        <= '0;
      lcnt_q        <= '0;
      dp_set_q      <= 1'b0;
      dp_register_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      blk_cnt_q     <= '0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      lcnt_q        <= lcnt_d;
      dp_set_q      <= dp_set_d;
      dp_register_q <= dp_register_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      blk_cnt_q     <= blk_cnt_d;
      rdy_q         <= rdy_d;
    end
  end

  assign s.in_ready   = in_ready;
  assign s.out_valid  = out_valid_q;
  assign s.out_data   = out_data_q;
  assign dp_set       = dp_set_q;
  assign dp_register  = dp_register_q;
  assign blk_cnt      = blk_cnt_q;
  assign busy         = (state_q != LOAD) || (wcnt_q != '0);

endmodule
